// File: rtl/butterworth_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade.
package butterworth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Coefficient order within one section's block of five
  localparam int B0    = 0;
  localparam int B1    = 1;
  localparam int B2    = 2;
  localparam int A1    = 3;
  localparam int A2    = 4;
  localparam int TERMS = 5;

  // Four guard bits cover the sum of five full-scale products
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 4;
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate with rounding and DATA_W reduction of each section result.
// Define BUTTERWORTH_SAT_EN to saturate section results; otherwise they wrap.
module biquad_mac
  import butterworth_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     en,
  input  logic                     last,
  input  logic                     sub,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [DATA_W-1:0] result
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(2 ** (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  acc_reg;

  assign prod    = PROD_W'(sample) * PROD_W'(coef);
  assign term    = sub ? -ACC_W'(prod) : ACC_W'(prod);
  assign sum     = acc_reg + term;
  assign shifted = (sum + RND) >>> FRAC_W;

`ifdef BUTTERWORTH_SAT_EN
  always_comb begin
    result = shifted[DATA_W-1:0];
    if (shifted > MAXV)      result = MAXV[DATA_W-1:0];
    else if (shifted < MINV) result = MINV[DATA_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^{shifted[ACC_W-1:DATA_W], MAXV, MINV};
  assign result    = shifted[DATA_W-1:0];
`endif

  // The final term of a section is folded in combinationally, so the accumulator restarts at zero
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    acc_reg <= '0;
    else if (en)   acc_reg <= last ? '0 : sum;
  end

endmodule

// File: rtl/butterworth_biquad_cascade.sv
// N_SEC Direct Form I biquads sharing one MAC, one term per cycle; sample-in/sample-out handshakes.
// Define BUTTERWORTH_SAT_EN to saturate each section result instead of wrapping.
module butterworth_biquad_cascade
  import butterworth_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int N_SEC  = 2
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic signed [DATA_W-1:0]         in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic signed [DATA_W-1:0]         out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             coef_we,
  input  logic [$clog2(5*N_SEC)-1:0]       coef_addr,
  input  logic signed [COEF_W-1:0]         coef_wdata,
  output logic                             busy
);

  localparam int N_COEF = TERMS * N_SEC;
  localparam int AW     = $clog2(N_COEF);
  localparam int SW     = (N_SEC > 1) ? $clog2(N_SEC) : 1;
  localparam logic [AW:0] COEF_LIMIT = (AW+1)'(N_COEF);
  localparam logic signed [COEF_W-1:0] ONE = COEF_W'(2 ** FRAC_W);

  state_t state_reg, state_next;
  logic [AW-1:0] idx_reg;
  logic [2:0]    term_reg;
  logic [SW-1:0] sec_reg;
  logic signed [DATA_W-1:0] cur_x_reg, out_data_reg;
  logic signed [COEF_W-1:0] coef_mem [N_COEF];
  logic signed [DATA_W-1:0] x1_mem [N_SEC];
  logic signed [DATA_W-1:0] x2_mem [N_SEC];
  logic signed [DATA_W-1:0] y1_mem [N_SEC];
  logic signed [DATA_W-1:0] y2_mem [N_SEC];

  logic signed [DATA_W-1:0] operand, res;
  logic mac_en, last_term, last_sec, coef_wr;

  assign mac_en    = (state_reg == MAC);
  assign last_term = (term_reg == 3'(A2));
  assign last_sec  = (sec_reg == SW'(N_SEC - 1));
  assign coef_wr   = coef_we && (state_reg == IDLE) && ({1'b0, coef_addr} < COEF_LIMIT);
  assign out_data  = out_data_reg;

  always_comb begin
    operand = cur_x_reg;
    case (term_reg)
      3'(B1):  operand = x1_mem[sec_reg];
      3'(B2):  operand = x2_mem[sec_reg];
      3'(A1):  operand = y1_mem[sec_reg];
      3'(A2):  operand = y2_mem[sec_reg];
      default: operand = cur_x_reg;
    endcase
  end

  biquad_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)) u_mac (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .en     (mac_en),
    .last   (last_term),
    .sub    (term_reg >= 3'(A1)),
    .sample (operand),
    .coef   (coef_mem[idx_reg]),
    .result (res)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = MAC;
      end
      MAC:  if (last_term && last_sec) state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencing: coefficient index, term within section, and the section's input sample
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_reg      <= '0;
      term_reg     <= '0;
      sec_reg      <= '0;
      cur_x_reg    <= '0;
      out_data_reg <= '0;
    end else if (state_reg == IDLE) begin
      idx_reg  <= '0;
      term_reg <= '0;
      sec_reg  <= '0;
      if (in_valid) cur_x_reg <= in_data;
    end else if (mac_en) begin
      idx_reg <= idx_reg + AW'(1);
      if (last_term) begin
        term_reg  <= '0;
        sec_reg   <= sec_reg + SW'(1);
        cur_x_reg <= res;
        if (last_sec) out_data_reg <= res;
      end else begin
        term_reg <= term_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_COEF; i++) coef_mem[i] <= ((i % TERMS) == B0) ? ONE : '0;
    end else if (coef_wr) begin
      coef_mem[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_SEC; i++) begin
        x1_mem[i] <= '0;
        x2_mem[i] <= '0;
        y1_mem[i] <= '0;
        y2_mem[i] <= '0;
      end
    end else if (mac_en && last_term) begin
      x2_mem[sec_reg] <= x1_mem[sec_reg];
      x1_mem[sec_reg] <= cur_x_reg;
      y2_mem[sec_reg] <= y1_mem[sec_reg];
      y1_mem[sec_reg] <= res;
    end
  end

endmodule

// File: tb/tb_butterworth_biquad_cascade.sv
// Scoreboard bench for butterworth_biquad_cascade against a per-sample difference-equation model.
module tb_butterworth_biquad_cascade;

  localparam int N  = 2;
  localparam int NC = 5 * N;
  localparam int F  = 14;
`ifdef BUTTERWORTH_SAT_EN
  localparam int OVF_EXP = 32767;
`else
  localparam int OVF_EXP = -5538;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic signed [15:0] in_data = '0;
  logic in_valid = 1'b0, in_ready;
  logic signed [15:0] out_data;
  logic out_valid, out_ready = 1'b1;
  logic coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic signed [15:0] coef_wdata = '0;
  logic busy;

  int vecs = 0;
  int errs = 0;
  logic signed [15:0] exp_q[$];

  longint m_coef[NC];
  longint m_x1[N], m_x2[N], m_y1[N], m_y2[N];

  always #5 CLK = ~CLK;

  butterworth_biquad_cascade #(.DATA_W(16), .COEF_W(16), .FRAC_W(F), .N_SEC(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy)
  );

  function automatic longint reduce(input longint v);
`ifdef BUTTERWORTH_SAT_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return ((v + 32768) & 65535) - 32768;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) m_coef[i] = (i % 5 == 0) ? (64'sd1 <<< F) : 0;
    for (int s = 0; s < N; s++) begin
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
  endfunction

  function automatic logic signed [15:0] model_step(input longint xin);
    longint x, acc, y;
    x = xin;
    for (int s = 0; s < N; s++) begin
      acc = m_coef[5*s] * x + m_coef[5*s+1] * m_x1[s] + m_coef[5*s+2] * m_x2[s]
          - m_coef[5*s+3] * m_y1[s] - m_coef[5*s+4] * m_y2[s];
      y = reduce((acc + (64'sd1 <<< (F - 1))) >>> F);
      m_x2[s] = m_x1[s]; m_x1[s] = x;
      m_y2[s] = m_y1[s]; m_y1[s] = y;
      x = y;
    end
    return 16'(x);
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (RST_N && out_valid && out_ready) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_output got=%0d", out_data);
      end else begin
        logic signed [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errs++;
          $display("FAIL out_data got=%0d expected=%0d", out_data, e);
        end
        $display("out %0d expected %0d", out_data, e);
      end
    end
  end

  task automatic do_reset();
    RST_N = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic signed [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(posedge CLK);
    #1 coef_we = 1'b0;
    if (a < 4'(NC)) m_coef[a] = longint'(d);
  endtask

  // Issue one sample, push its expectation, and return once out_valid is seen
  task automatic send(input logic signed [15:0] x, output logic signed [15:0] got);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge CLK); #1; n++; end
    if (n >= 100) begin errs++; $display("FAIL in_ready_timeout got=0 expected=1"); end
    in_valid = 1'b1; in_data = x;
    exp_q.push_back(model_step(longint'(x)));
    @(posedge CLK);
    #1 in_valid = 1'b0; in_data = 16'($urandom);
    n = 0;
    do begin @(negedge CLK); n++; end while (!out_valid && n < 200);
    chk("latency", n, NC + 1);
    got = out_data;
  endtask

  task automatic finish_out(input int stall);
    repeat (stall) @(posedge CLK);
    #1 out_ready = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic xfer(input logic signed [15:0] x, output logic signed [15:0] got, input int stall);
    out_ready = (stall == 0);
    send(x, got);
    finish_out(stall);
  endtask

  initial begin
    logic signed [15:0] got, held;
    model_reset();
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    @(posedge CLK); #1 RST_N = 1'b1;
    #1 chk("reset_in_ready", in_ready, 1);

    xfer(16'sd1000, got, 0);
    chk("passthrough", got, 1000);

    do_reset();
    wr_coef(4'd0, 16'sh2000);
    wr_coef(4'd1, 16'sh2000);
    xfer(16'sd16384, got, 0); chk("impulse_0", got, 8192);
    xfer(16'sd0, got, 0);     chk("impulse_1", got, 8192);
    xfer(16'sd0, got, 0);     chk("impulse_2", got, 0);

    do_reset();
    wr_coef(4'd0, 16'sh7FFF);
    xfer(16'sd30000, got, 0); chk("overflow", got, OVF_EXP);

    do_reset();
    out_ready = 1'b0;
    send(16'sd500, held);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, held);
      chk("stall_in_ready", in_ready, 0);
    end
    finish_out(1);

    do_reset();
    fork
      begin xfer(16'sd321, got, 0); end
      begin
        repeat (3) @(posedge CLK);
        #1 coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'sh1234;
        @(negedge CLK) chk("busy_during_write", busy, 1);
        @(posedge CLK); #1 coef_we = 1'b0;
      end
    join
    xfer(16'sd321, got, 0); chk("write_while_busy", got, 321);

    wr_coef(4'd12, 16'sh4000);
    wr_coef(4'd15, 16'sh0100);
    xfer(-16'sd777, got, 0); chk("addr_out_of_range", got, -777);

    do_reset();
    for (int i = 0; i < NC; i++)
      wr_coef(4'(i), (i % 5 < 3) ? 16'($signed($urandom_range(0, 16384)) - 8192)
                                 : 16'($signed($urandom_range(0, 8192)) - 4096));
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1 xfer(16'($urandom_range(0, 65535)), got, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a sample: no output, history and coefficients restart
    while (!in_ready) begin @(posedge CLK); #1; end
    in_valid = 1'b1; in_data = 16'sd777;
    @(posedge CLK); #1 in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1 chk("midreset_out_valid", out_valid, 0);
    chk("midreset_busy", busy, 0);
    @(posedge CLK); #1 RST_N = 1'b1;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      chk("midreset_no_output", out_valid, 0);
    end
    #1 xfer(16'sd1234, got, 0); chk("after_midreset", got, 1234);

    repeat (3) @(posedge CLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    errs++;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/butterworth_biquad_cascade.md
BUTTERWORTH_BIQUAD_CASCADE -- requirements
Module: butterworth_biquad_cascade

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed sample width.
REQ-002 SHALL have parameter COEF_W, default 16, meaning signed coefficient width.
REQ-003 SHALL have parameter FRAC_W, default 14, meaning coefficient fractional bits.
REQ-004 SHALL have parameter N_SEC, default 2 (range 1..8), meaning number of cascaded second-order sections.
REQ-005 SHALL have port CLK, input, 1, the single clock.
REQ-006 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_data, input, DATA_W, signed input sample.
REQ-008 SHALL have port in_valid, input, 1, input sample present.
REQ-009 SHALL have port in_ready, output, 1, block accepts a sample.
REQ-010 SHALL have port out_data, output, DATA_W, signed filtered sample.
REQ-011 SHALL have port out_valid, output, 1, out_data valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-013 SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-014 SHALL have port coef_addr, input, clog2(5*N_SEC), coefficient index: section*5 + {0:b0,1:b1,2:b2,3:a1,4:a2}.
REQ-015 SHALL have port coef_wdata, input, COEF_W, signed coefficient in Q(COEF_W-FRAC_W).FRAC_W.
REQ-016 SHALL have port busy, output, 1, high outside IDLE.

Function
REQ-017 SHALL compute per section, Direct Form I: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, section k output feeding section k+1.
REQ-018 SHALL use one shared multiplier and one accumulator of width DATA_W+COEF_W+4, one MAC term per cycle.
REQ-019 SHALL run FSM IDLE -> MAC (5 cycles per section, N_SEC sections) -> OUT -> IDLE.
REQ-020 SHALL assert in_ready only in IDLE; transfer occurs on in_valid && in_ready.
REQ-021 SHALL, at end of each section, round (add 2^(FRAC_W-1)), arithmetic right-shift by FRAC_W, reduce to DATA_W, and update that section's x1/x2/y1/y2 history.
REQ-022 SHALL assert out_valid in OUT exactly 5*N_SEC+1 cycles after the accepting edge; hold out_data stable until out_valid && out_ready, then return to IDLE.
REQ-023 SHALL allow in_valid/in_ready and out handshake never in the same cycle (no overlap; throughput 1 sample per 5*N_SEC+2 cycles with out_ready held high).
REQ-024 SHALL accept coef_we only in IDLE; writes while busy SHALL be ignored; addresses >= 5*N_SEC SHALL be ignored.
REQ-025 SHALL leave history unchanged on coefficient writes.

Reset
REQ-026 SHALL, on RST_N low, immediately clear state to IDLE, accumulator, all history, out_data=0, out_valid=0, busy=0; in_ready=1 after release.
REQ-027 SHALL reset coefficients to b0=2^FRAC_W (1.0), all others 0 (pass-through).
REQ-028 SHALL abandon any in-flight sample on reset mid-operation with no output produced.

Configuration
REQ-029 SHALL, with BUTTERWORTH_SAT_EN defined, saturate each section result to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-030 SHALL, without BUTTERWORTH_SAT_EN, truncate (two's-complement wrap) each section result to DATA_W bits.

Structure
REQ-031 SHALL place FSM state enum, coefficient index constants (B0..A2) and accumulator-width function in package butterworth_pkg.
REQ-032 SHALL instantiate one sub-module biquad_mac (multiplier, accumulator, round/shift/saturate); FSM, history and coefficient storage remain in the top.

Verification
REQ-033 SHALL cover: after reset, N_SEC=2, in_data=1000 -> out_data=1000 after 11 cycles (pass-through).
REQ-034 SHALL cover: section 0 b0=b1=0x2000 (0.5), others default; impulse 16384 then zeros -> outputs 8192, 8192, 0.
REQ-035 SHALL cover: b0=0x7FFF (~2.0), in_data=30000 -> 32767 with BUTTERWORTH_SAT_EN, wrapped negative value without it.
REQ-036 SHALL cover: out_ready low 20 cycles -> out_valid and out_data held, in_ready low throughout.
REQ-037 SHALL cover: coef_we asserted while busy -> coefficient unchanged, next output equal to pre-write expectation.
REQ-038 SHALL cover: RST_N low during MAC -> out_valid 0, next accepted sample filtered from zero history.
